// File: rtl/psum_pkg.sv
// +----------------------------------------------------------------------------+
// | Module   : psum_pkg                                                         |
// | Purpose  : Shared types and constants for the partial-sum accumulator.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package psum_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int CNT_W_DEF = 8;

    typedef struct packed {
        logic signed [ACC_W_DEF-1:0] data;
        logic        [CNT_W_DEF-1:0] terms;
        logic                        sat;
    } psum_res_t;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_t;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_TWO   = 2'd2
    } fifo_state_t;

    // Two's-complement limits of a w-bit signed value, returned in 32 bits.
    function automatic logic [31:0] SAT_MAX(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] SAT_MIN(input int w);
        return ~SAT_MAX(w);
    endfunction

endpackage

`default_nettype wire

// File: rtl/psum_fifo2.sv
// +----------------------------------------------------------------------------+
// | Module   : psum_fifo2                                                       |
// | Purpose  : Two-entry valid/ready result buffer; pushes into a full buffer   |
// |            without a simultaneous pop are discarded.                        |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module psum_fifo2
    import psum_pkg::*;
#(
    parameter type T = psum_res_t
)(
    input  logic clk,
    input  logic rstn,
    input  logic i_push,
    input  T     i_data,
    output logic o_full,
    output logic o_valid,
    input  logic i_ready,
    output T     o_data
);

    fifo_state_t r_state;
    T            r_head;
    T            r_tail;
    logic        w_pop;

    assign w_pop   = (r_state != FIFO_EMPTY) && i_ready;
    assign o_full  = (r_state == FIFO_TWO);
    assign o_valid = (r_state != FIFO_EMPTY);
    assign o_data  = r_head;

    // Head is always the oldest entry; a pop shifts the tail forward.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= FIFO_EMPTY;
            r_head  <= '0;
            r_tail  <= '0;
        end else begin
            case (r_state)
                FIFO_EMPTY: begin
                    if (i_push) begin
                        r_head  <= i_data;
                        r_state <= FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    if (w_pop && i_push) begin
                        r_head <= i_data;
                    end else if (w_pop) begin
                        r_state <= FIFO_EMPTY;
                    end else if (i_push) begin
                        r_tail  <= i_data;
                        r_state <= FIFO_TWO;
                    end
                end
                FIFO_TWO: begin
                    if (w_pop) begin
                        r_head <= r_tail;
                        if (i_push) begin
                            r_tail <= i_data;
                        end else begin
                            r_state <= FIFO_ONE;
                        end
                    end
                end
                default: r_state <= FIFO_EMPTY;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/psum_accumulator.sv
// +----------------------------------------------------------------------------+
// | Module   : psum_accumulator                                                 |
// | Purpose  : Saturating partial-sum accumulator for MAC products with a       |
// |            two-entry output buffer. Define PSUM_RELU_EN to clamp negative   |
// |            results to zero at push time.                                    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module psum_accumulator
    import psum_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
)(
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    prod_valid,
    input  logic signed [15:0]      prod,
    input  logic                    prod_last,
    input  logic                    acc_clr,
    output logic                    psum_valid,
    input  logic                    psum_ready,
    output logic signed [ACC_W-1:0] psum_data,
    output logic [CNT_W-1:0]        psum_terms,
    output logic                    psum_sat,
    output logic                    ovf_err,
    input  logic                    err_clr
);

    typedef struct packed {
        logic signed [ACC_W-1:0] data;
        logic        [CNT_W-1:0] terms;
        logic                    sat;
    } res_t;

    localparam logic [31:0]             c_MAX32   = SAT_MAX(ACC_W);
    localparam logic [31:0]             c_MIN32   = SAT_MIN(ACC_W);
    localparam logic signed [ACC_W-1:0] c_SAT_MAX = c_MAX32[ACC_W-1:0];
    localparam logic signed [ACC_W-1:0] c_SAT_MIN = c_MIN32[ACC_W-1:0];
    localparam logic [CNT_W-1:0]        c_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    acc_state_t              r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_terms;
    logic                    r_sat;
    logic                    r_ovf_err;

    logic                    w_fresh;
    logic signed [ACC_W-1:0] w_base;
    logic [CNT_W-1:0]        w_base_terms;
    logic                    w_base_sat;
    logic [ACC_W:0]          w_wide;
    logic                    w_ovf;
    logic signed [ACC_W-1:0] w_sum;
    logic [CNT_W-1:0]        w_terms;
    logic                    w_sat;
    logic                    w_push;
    logic                    w_full;
    logic                    w_drop;
    res_t                    w_push_res;
    res_t                    w_head;

    // A fresh sum starts from zero when idle or when the old sum is discarded.
    assign w_fresh = (r_state == ST_IDLE) || acc_clr;

    always_comb begin
        w_base       = w_fresh ? '0 : r_acc;
        w_base_terms = w_fresh ? '0 : r_terms;
        w_base_sat   = w_fresh ? 1'b0 : r_sat;
        w_wide       = {w_base[ACC_W-1], w_base} + {{(ACC_W-15){prod[15]}}, prod};
        w_ovf        = w_wide[ACC_W] ^ w_wide[ACC_W-1];
        if (!w_ovf) begin
            w_sum = w_wide[ACC_W-1:0];
        end else if (w_wide[ACC_W]) begin
            w_sum = c_SAT_MIN;
        end else begin
            w_sum = c_SAT_MAX;
        end
        w_sat   = w_base_sat || w_ovf;
        w_terms = (&w_base_terms) ? w_base_terms : (w_base_terms + c_ONE);
    end

    always_comb begin
        w_push_res.terms = w_terms;
        w_push_res.sat   = w_sat;
`ifdef PSUM_RELU_EN
        w_push_res.data  = w_sum[ACC_W-1] ? '0 : w_sum;
`else
        w_push_res.data  = w_sum;
`endif
    end

    assign w_push = prod_valid && prod_last;
    assign w_drop = w_push && w_full && !(psum_valid && psum_ready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_terms <= '0;
            r_sat   <= 1'b0;
        end else if (prod_valid && !prod_last) begin
            r_state <= ST_ACCUM;
            r_acc   <= w_sum;
            r_terms <= w_terms;
            r_sat   <= w_sat;
        end else if (prod_valid || acc_clr) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_terms <= '0;
            r_sat   <= 1'b0;
        end
    end

    // A drop in the same cycle as err_clr wins so no overflow goes unreported.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ovf_err <= 1'b0;
        end else if (w_drop) begin
            r_ovf_err <= 1'b1;
        end else if (err_clr) begin
            r_ovf_err <= 1'b0;
        end
    end

    psum_fifo2 #(
        .T       (res_t)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_push  (w_push),
        .i_data  (w_push_res),
        .o_full  (w_full),
        .o_valid (psum_valid),
        .i_ready (psum_ready),
        .o_data  (w_head)
    );

    assign psum_data  = w_head.data;
    assign psum_terms = w_head.terms;
    assign psum_sat   = w_head.sat;
    assign ovf_err    = r_ovf_err;

endmodule

`default_nettype wire

// File: tb/tb_psum_accumulator.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_psum_accumulator                                              |
// | Purpose  : Self-checking bench for psum_accumulator (24-bit and 17-bit).    |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_psum_accumulator;

    logic               clk = 1'b0;
    logic               rstn;
    logic               prod_valid;
    logic signed [15:0] prod;
    logic               prod_last;
    logic               acc_clr;
    logic               psum_ready;
    logic               err_clr;

    logic               psum_valid, psum_sat, ovf_err;
    logic [23:0]        psum_data;
    logic [7:0]         psum_terms;

    logic               v17, sat17, ovf17;
    logic [16:0]        data17;
    logic [3:0]         terms17;

    always #5 clk = ~clk;

    psum_accumulator #(.ACC_W(24), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .prod_valid(prod_valid), .prod(prod),
        .prod_last(prod_last), .acc_clr(acc_clr), .psum_valid(psum_valid),
        .psum_ready(psum_ready), .psum_data(psum_data), .psum_terms(psum_terms),
        .psum_sat(psum_sat), .ovf_err(ovf_err), .err_clr(err_clr)
    );

    psum_accumulator #(.ACC_W(17), .CNT_W(4)) dut17 (
        .clk(clk), .rstn(rstn), .prod_valid(prod_valid), .prod(prod),
        .prod_last(prod_last), .acc_clr(acc_clr), .psum_valid(v17),
        .psum_ready(psum_ready), .psum_data(data17), .psum_terms(terms17),
        .psum_sat(sat17), .ovf_err(ovf17), .err_clr(err_clr)
    );

    typedef struct {
        bit pv; int prod; bit last; bit clr; bit ready; bit eclr;
        int e_data; int e_terms; bit e_sat;
    } vec_t;

    typedef struct {
        logic [23:0] data; logic [7:0] terms; logic sat;
    } exp_t;

    exp_t        sbq[$];
    vec_t        tbl[$];
    bit          m_ovf;
    int          checks;
    int          errors;
    logic [22:0] s17;

    function automatic vec_t V(bit pv, int p, bit last, bit clr, bit ready, bit eclr,
                               int ed = 0, int et = 0, bit es = 1'b0);
        vec_t v;
        v.pv = pv; v.prod = p; v.last = last; v.clr = clr; v.ready = ready; v.eclr = eclr;
        v.e_data = ed; v.e_terms = et; v.e_sat = es;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // One clock: drive, compare at negedge against the scoreboard head, then model the edge.
    task automatic step(input vec_t v, input string nm);
        exp_t e;
        bit   pop, push, drop;
        prod_valid = v.pv; prod = 16'(v.prod); prod_last = v.last;
        acc_clr = v.clr; psum_ready = v.ready; err_clr = v.eclr;
        @(negedge clk);
        s17 = {v17, data17, terms17, sat17};
        if (sbq.size() > 0)
            chk(nm, {29'b0, psum_valid, psum_data, psum_terms, psum_sat, ovf_err},
                    {29'b0, 1'b1, sbq[0].data, sbq[0].terms, sbq[0].sat, m_ovf});
        else
            chk(nm, {62'b0, psum_valid, ovf_err}, {62'b0, 1'b0, m_ovf});
        pop  = (sbq.size() > 0) && v.ready;
        push = v.pv && v.last;
        drop = push && (sbq.size() == 2) && !pop;
        e.data  = 24'(v.e_data);
`ifdef PSUM_RELU_EN
        if (v.e_data < 0) e.data = '0;
`endif
        e.terms = 8'(v.e_terms);
        e.sat   = v.e_sat;
        if (pop) void'(sbq.pop_front());
        if (push && !drop) sbq.push_back(e);
        m_ovf = drop ? 1'b1 : (v.eclr ? 1'b0 : m_ovf);
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0; m_ovf = 1'b0;
        rstn = 1'b0; prod_valid = 0; prod = '0; prod_last = 0;
        acc_clr = 0; psum_ready = 1; err_clr = 0;

        // pv, prod, last, clr, ready, eclr, exp data, exp terms, exp sat
        tbl.push_back(V(1, 100, 0, 0, 1, 0));
        tbl.push_back(V(1, -30, 0, 0, 1, 0));
        tbl.push_back(V(1,   7, 1, 0, 1, 0, 77, 3, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));
        tbl.push_back(V(1,  -5, 1, 0, 1, 0, -5, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));
        tbl.push_back(V(1,   1, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(V(1,   2, 1, 0, 0, 0, 2, 1, 0));
        tbl.push_back(V(1,   3, 1, 0, 0, 0, 3, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 0, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 0, 1));
        tbl.push_back(V(0,   0, 0, 0, 0, 0));
        tbl.push_back(V(1,  10, 1, 0, 0, 0, 10, 1, 0));
        tbl.push_back(V(1,  20, 1, 0, 0, 0, 20, 1, 0));
        tbl.push_back(V(1,  30, 1, 0, 1, 0, 30, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));
        tbl.push_back(V(1,  10, 0, 0, 1, 0));
        tbl.push_back(V(1,  20, 0, 0, 1, 0));
        tbl.push_back(V(0,   0, 0, 1, 1, 0));
        tbl.push_back(V(1,   5, 1, 0, 1, 0, 5, 1, 0));
        tbl.push_back(V(1,  10, 0, 0, 1, 0));
        tbl.push_back(V(1,  20, 0, 0, 1, 0));
        tbl.push_back(V(1,   5, 1, 1, 1, 0, 5, 1, 0));
        tbl.push_back(V(1,  40, 0, 0, 1, 0));
        tbl.push_back(V(1,   8, 0, 1, 1, 0));
        tbl.push_back(V(1,   2, 1, 0, 1, 0, 10, 2, 0));
        tbl.push_back(V(1,   4, 1, 0, 1, 0, 4, 1, 0));
        tbl.push_back(V(1,  -4, 1, 0, 1, 0, -4, 1, 0));
        tbl.push_back(V(1,   6, 1, 0, 1, 0, 6, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));
        tbl.push_back(V(1,   1, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(V(1,   2, 1, 0, 0, 0, 2, 1, 0));
        tbl.push_back(V(1,   3, 1, 0, 0, 0, 3, 1, 0));
        tbl.push_back(V(1,   4, 1, 0, 0, 1, 4, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 0, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));
        tbl.push_back(V(0,   0, 0, 0, 1, 1));
        tbl.push_back(V(0,   0, 0, 0, 1, 0));

        #12;
        chk("reset_state", {29'b0, psum_valid, psum_data, psum_terms, psum_sat, ovf_err}, 64'd0);
        chk("reset_state17", {40'b0, v17, data17, terms17, sat17, ovf17}, 64'd0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;

        // Saturation at the 17-bit width, positive then negative.
        step(V(1, 32767, 0, 0, 1, 0), "sat_pos_a");
        step(V(1, 32767, 0, 0, 1, 0), "sat_pos_b");
        step(V(1, 32767, 1, 0, 1, 0, 98301, 3, 0), "sat_pos_c");
        step(V(0, 0, 0, 0, 1, 0), "sat_pos_d");
        chk("sat_pos17", 64'(s17), 64'({1'b1, 17'h0FFFF, 4'd3, 1'b1}));
        step(V(1, -32767, 0, 0, 1, 0), "sat_neg_a");
        step(V(1, -32767, 0, 0, 1, 0), "sat_neg_b");
        step(V(1, -32767, 1, 0, 1, 0, -98301, 3, 0), "sat_neg_c");
        step(V(0, 0, 0, 0, 1, 0), "sat_neg_d");
`ifdef PSUM_RELU_EN
        chk("sat_neg17", 64'(s17), 64'({1'b1, 17'h00000, 4'd3, 1'b1}));
`else
        chk("sat_neg17", 64'(s17), 64'({1'b1, 17'h10000, 4'd3, 1'b1}));
`endif

        // Term counter saturation on the 4-bit instance.
        for (int i = 0; i < 19; i++) step(V(1, 1, 0, 0, 1, 0), "terms_acc");
        step(V(1, 1, 1, 0, 1, 0, 20, 20, 0), "terms_last");
        step(V(0, 0, 0, 0, 1, 0), "terms_out");
        chk("terms_sat17", 64'(s17), 64'({1'b1, 17'd20, 4'd15, 1'b0}));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("vec%0d", i));

        // Reset in the middle of a vector with a buffered result.
        step(V(1, 3, 1, 0, 0, 0, 3, 1, 0), "rst_pre_a");
        step(V(1, 50, 0, 0, 0, 0), "rst_pre_b");
        step(V(1, 60, 0, 0, 0, 0), "rst_pre_c");
        prod_valid = 0; prod_last = 0; psum_ready = 1;
        rstn = 1'b0;
        #2;
        chk("reset_mid", {29'b0, psum_valid, psum_data, psum_terms, psum_sat, ovf_err}, 64'd0);
        sbq.delete();
        m_ovf = 1'b0;
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        step(V(1, 9, 1, 0, 1, 0, 9, 1, 0), "post_rst_a");
        step(V(0, 0, 0, 0, 1, 0), "post_rst_b");
        step(V(0, 0, 0, 0, 1, 0), "post_rst_c");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/psum_accumulator.md
# psum_accumulator

Downstream consumer of the bit-serial MAC unit. It captures each 16-bit signed product on the cycle the MAC asserts its done strobe and accumulates products into a wide saturating partial sum. On the last term of a dot product it pushes the sum into a 2-entry output buffer drained by a valid/ready handshake. The MAC cannot be stalled, so this block never back-pressures its input; it drops results on buffer overflow and flags the drop.

## Interface
- ACC_W, 24: accumulator and output width in bits, signed; legal range 17..32.
- CNT_W, 8: term-counter width.
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- prod_valid  in  1  one-cycle strobe; prod is valid this cycle.
- prod  in  16  signed product from the MAC.
- prod_last  in  1  qualifies prod_valid; this product is the final term of the dot product.
- acc_clr  in  1  synchronous discard of the in-progress partial sum.
- psum_valid  out  1  output buffer head is valid.
- psum_ready  in  1  consumer accepts the head.
- psum_data  out  ACC_W  result.
- psum_terms  out  CNT_W  number of products summed into psum_data; saturates at all-ones.
- psum_sat  out  1  saturation occurred during this result.
- ovf_err  out  1  sticky: a result was dropped because the buffer was full.
- err_clr  in  1  clears ovf_err.

## Operation
- Accumulator FSM:
  - IDLE: acc = 0, terms = 0, sat = 0.
  - ACCUM: at least one term held.
- IDLE + prod_valid & !prod_last → ACCUM, acc = sext(prod).
- ACCUM + prod_valid & !prod_last → stays in ACCUM; acc += sext(prod).
- prod_valid & prod_last, from either state → push {acc+sext(prod), terms+1, sat}, then → IDLE. A single-term vector is legal.
- Arithmetic: signed ACC_W-bit add.
  - On overflow the sum clamps to +2^(ACC_W-1)-1 or -2^(ACC_W-1) and the sat flag sets.
  - Further terms keep adding to the clamped value.
- acc_clr:
  - Without prod_valid: → IDLE, partial sum discarded, nothing pushed.
  - With prod_valid: the old sum is discarded and prod starts a fresh sum (or, if prod_last, is pushed alone).
- Output buffer:
  - 2-entry FIFO with states EMPTY, ONE, TWO.
  - Pop occurs when psum_valid & psum_ready.
  - Push and pop in the same cycle are always permitted, including in TWO; the pop frees the slot.
  - Push in TWO without a pop drops the new result and sets ovf_err. Buffer contents are unchanged.
- ovf_err: err_clr clears it. If err_clr and a new drop coincide, the flag stays set.

## Timing
- Reset value of every output is 0; FSM resets to IDLE and the buffer to EMPTY.
- Reset mid-vector loses the partial sum and the buffered results.
- Latency: prod_valid & prod_last in cycle N → psum_valid high in cycle N+1, with psum_data, psum_terms and psum_sat registered.
- Throughput: one product per cycle, fully pipelined. Back-to-back prod_last every cycle is sustained only if psum_ready stays high.
- psum_data, psum_terms and psum_sat hold stable while psum_valid & !psum_ready.
- ovf_err rises the cycle after the dropping push.

## Configuration
- PSUM_RELU_EN defined: negative results are replaced by 0 at push time. psum_sat still reflects accumulation saturation.
- PSUM_RELU_EN undefined: results are emitted signed, unmodified.

## Structure
- Package psum_pkg holds:
  - default ACC_W and CNT_W;
  - the packed result struct {data, terms, sat};
  - the FSM state enum;
  - the SAT_MAX/SAT_MIN constant functions.
- Sub-module psum_fifo2: the 2-entry valid/ready buffer carrying the result struct, with a full output and a drop-on-full push.

## Test plan
- Products 100, -30, 7 (last on 7) → one result: data 77, terms 3, sat 0, psum_valid at cycle N+1.
- Single product -5 with prod_last, ACC_W=24 → data -5 (all-ones pattern 0xFFFFFB); with PSUM_RELU_EN → data 0.
- ACC_W=17, products 32767, 32767, 32767 (last) → data 65535, sat 1; the same sequence in negative → -65536, sat 1.
- psum_ready low, three single-term vectors 1, 2, 3 → buffer holds 1, 2; value 3 dropped; ovf_err=1. Raising psum_ready then yields 1 and then 2; err_clr clears ovf_err.
- Buffer TWO with psum_ready high and a push in the same cycle → no drop, ovf_err stays 0, output order preserved.
- acc_clr mid-vector after 10, 20, then product 5 with prod_last → result 5, terms 1. rstn pulsed low mid-vector → all outputs 0 immediately and the next vector sums from 0.
